// File: rtl/hf_pkg.sv
`default_nettype none
// ============================================================================
//  hf_pkg
//  Shared types and constants for the history-file writeback path.
//  Revision: 1.0
// ============================================================================
package hf_pkg;

    localparam int XLEN_DEF = 32;
    localparam logic [XLEN_DEF-1:0] EXC_NONE = '0;

    // Field slots of a writeback record; bit offset of a field is slot*XLEN
    localparam int HF_FLD_PC   = 0;
    localparam int HF_FLD_EXC  = 1;
    localparam int HF_FLD_MISS = 2;
    localparam int HF_NUM_FLD  = 3;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_BLOCK = 2'd1,
        ST_FLUSH = 2'd2
    } hf_state_e;

    function automatic int unsigned rr_wrap_inc(input int unsigned idx,
                                                input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  rr_arbiter
//  Combinational round-robin pick: first request at or after ptr_i, wrapping.
//  Revision: 1.0
// ============================================================================
module rr_arbiter #(
    parameter  int N  = 3,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    int j;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        j       = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr_i) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!any_o && req_i[j[IW-1:0]]) begin
                any_o              = 1'b1;
                idx_o              = j[IW-1:0];
                grant_o[j[IW-1:0]] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/hf_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  hf_wb_arbiter
//  Round-robin writeback arbiter feeding the history file's completion port.
//  Revision: 1.0
// ============================================================================
module hf_wb_arbiter
    import hf_pkg::*;
#(
    parameter  int N_REQ = 3,
    parameter  int XLEN  = XLEN_DEF,
    localparam int IW    = $clog2(N_REQ)
) (
    input  logic                  clk_i,
    input  logic                  rsn_i,
    input  logic [N_REQ-1:0]      req_valid_i,
    output logic [N_REQ-1:0]      req_ready_o,
    input  logic [N_REQ*XLEN-1:0] req_pc_i,
    input  logic [N_REQ*XLEN-1:0] req_exc_i,
    input  logic [N_REQ*XLEN-1:0] req_miss_addr_i,
    input  logic                  hf_busy_i,
    input  logic                  kill_i,
    output logic                  wb_valid_o,
    output logic [XLEN-1:0]       wb_pc_o,
    output logic [XLEN-1:0]       wb_exc_o,
    output logic [XLEN-1:0]       wb_miss_addr_o,
    output logic [IW-1:0]         wb_src_o
);

    hf_state_e                 state_q, state_d;
    logic [IW-1:0]             rr_ptr_q, rr_ptr_d;
    logic                      wb_valid_q, wb_valid_d;
    logic [XLEN-1:0]           wb_pc_q, wb_pc_d;
    logic [XLEN-1:0]           wb_exc_q, wb_exc_d;
    logic [XLEN-1:0]           wb_miss_q, wb_miss_d;
    logic [IW-1:0]             wb_src_q, wb_src_d;

    logic [N_REQ-1:0]          arb_grant;
    logic [IW-1:0]             arb_idx;
    logic                      arb_any;
    logic                      grant_en;
    logic                      xfer;
    logic [HF_NUM_FLD*XLEN-1:0] sel_rec;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .req_i   (req_valid_i),
        .ptr_i   (rr_ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .any_o   (arb_any)
    );

    // Ready is held low while reset is asserted so no source sees a handshake.
    assign grant_en    = rsn_i && (state_q == ST_RUN) && !hf_busy_i && !kill_i;
    assign xfer        = grant_en && arb_any;
    assign req_ready_o = grant_en ? arb_grant : '0;

    always_comb begin
        sel_rec = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_grant[i]) begin
                sel_rec[HF_FLD_PC*XLEN   +: XLEN] |= req_pc_i[i*XLEN +: XLEN];
                sel_rec[HF_FLD_EXC*XLEN  +: XLEN] |= req_exc_i[i*XLEN +: XLEN];
                sel_rec[HF_FLD_MISS*XLEN +: XLEN] |= req_miss_addr_i[i*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        wb_valid_d = xfer;
        wb_pc_d    = wb_pc_q;
        wb_exc_d   = wb_exc_q;
        wb_miss_d  = wb_miss_q;
        wb_src_d   = wb_src_q;

        // Kill outranks busy; FLUSH and BLOCK both fall back through the same rule.
        if (kill_i) begin
            state_d = ST_FLUSH;
        end else if (hf_busy_i) begin
            state_d = ST_BLOCK;
        end else begin
            state_d = ST_RUN;
        end

        if (xfer) begin
            wb_pc_d   = sel_rec[HF_FLD_PC*XLEN   +: XLEN];
            wb_exc_d  = sel_rec[HF_FLD_EXC*XLEN  +: XLEN];
            wb_miss_d = sel_rec[HF_FLD_MISS*XLEN +: XLEN];
            wb_src_d  = arb_idx;
            rr_ptr_d  = IW'(rr_wrap_inc(32'(arb_idx), 32'(N_REQ)));
        end
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state_q    <= ST_RUN;
            rr_ptr_q   <= '0;
            wb_valid_q <= 1'b0;
            wb_pc_q    <= '0;
            wb_exc_q   <= XLEN'(EXC_NONE);
            wb_miss_q  <= '0;
            wb_src_q   <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            wb_valid_q <= wb_valid_d;
            wb_pc_q    <= wb_pc_d;
            wb_exc_q   <= wb_exc_d;
            wb_miss_q  <= wb_miss_d;
            wb_src_q   <= wb_src_d;
        end
    end

    assign wb_valid_o     = wb_valid_q;
    assign wb_pc_o        = wb_pc_q;
    assign wb_exc_o       = wb_exc_q;
    assign wb_miss_addr_o = wb_miss_q;
    assign wb_src_o       = wb_src_q;

endmodule
`default_nettype wire

// File: doc/hf_wb_arbiter.md
# hf_wb_arbiter

Writeback arbiter for the history file's single completion port. Up to N execution units (ALU, MUL, MEM) report completed instructions with PC, exception cause and miss address. Each cycle the block selects one completion by round-robin and forwards it, registered, to the history file's writeback inputs. It also suppresses issue while the history file is recovering and drops in-flight grants on a kill.

## Interface

Parameters:
- N_REQ, 3, number of completion sources (2..8)
- XLEN, 32, width of PC, exception and miss-address fields

Ports:
- clk_i  in  1  clock, rising edge
- rsn_i  in  1  reset, asynchronous, active-low
- req_valid_i  in  N_REQ  completion valid per source
- req_ready_o  out  N_REQ  grant per source; transfer when valid & ready
- req_pc_i  in  N_REQ*XLEN  PC per source; source i at [i*XLEN +: XLEN]
- req_exc_i  in  N_REQ*XLEN  exception cause per source; 0 = none
- req_miss_addr_i  in  N_REQ*XLEN  faulting address per source
- hf_busy_i  in  1  history file recovery in flight (its stall_decode_o)
- kill_i  in  1  pipeline kill (history file kill_instr_o)
- wb_valid_o  out  1  writeback slot valid
- wb_pc_o  out  XLEN  PC to history file wb_pc_i
- wb_exc_o  out  XLEN  to wb_exc_i
- wb_miss_addr_o  out  XLEN  to wb_miss_addr_i
- wb_src_o  out  $clog2(N_REQ)  index of granted source (debug/perf)

## Operation

- FSM states: RUN, BLOCK, FLUSH. Reset state is RUN.
- RUN:
  - Grant goes to the first valid source at or after rr_ptr, wrapping modulo N_REQ.
  - req_ready_o is one-hot on the winner, zero otherwise.
  - Granted payload is registered to the wb_* outputs; rr_ptr becomes winner+1, wrapping (N_REQ-1 wraps to 0).
  - With no valid source there is no grant, wb_valid_o=0 next cycle, and rr_ptr is unchanged.
- hf_busy_i=1 in RUN: no grant, req_ready_o=0, go to BLOCK.
- BLOCK: no grant, req_ready_o=0, wb_valid_o=0. Return to RUN in the cycle after hf_busy_i falls.
- kill_i=1 in any state:
  - req_ready_o=0 that cycle; wb_valid_o forced 0 next cycle, overriding any grant.
  - Go to FLUSH.
  - kill_i has priority over hf_busy_i.
- FLUSH: one cycle, no grant, then RUN (or BLOCK if hf_busy_i=1). Sources drop their own killed requests; the arbiter holds no payload storage beyond the output register.
- wb_valid_o is high for exactly one cycle per grant. The payload registers hold their last value when invalid.
- Source contract: valid stays high with stable payload until ready. Max wait is N_REQ-1 grants.
- Reset values: wb_valid_o=0, wb_pc_o=0, wb_exc_o=0, wb_miss_addr_o=0, wb_src_o=0, req_ready_o=0, rr_ptr=0, state=RUN.
- Reset mid-operation: all of the above apply asynchronously. A grant in flight is lost; sources must also be reset.

## Timing

- req_ready_o is combinational from req_valid_i, rr_ptr, state, hf_busy_i and kill_i. No combinational path from ready back to valid.
- Latency: handshake in cycle t gives wb_* valid in cycle t+1. Throughput is 1 completion per cycle.
- hf_busy_i or kill_i asserted in cycle t blocks the grant in cycle t itself.
- Simultaneous kill_i and grant-eligible requests: no transfer occurs, and rr_ptr is unchanged.
- Single valid source with rr_ptr pointing elsewhere: that source is still granted the same cycle.

## Structure

- Shared package hf_pkg holds:
  - XLEN_DEF=32 and EXC_NONE='0
  - state enum {RUN, BLOCK, FLUSH}
  - history-file field offsets, shared with history_file
- Sub-module rr_arbiter (N parameter) is the natural split: request vector plus pointer in, one-hot grant and encoded index out, purely combinational.
- The top module holds the FSM, rr_ptr, output registers and payload mux.

## Test plan

- Only source 1 valid with PC 0x100, exc 0: req_ready_o=3'b010 in cycle t; wb_valid_o=1, wb_pc_o=0x100, wb_src_o=1 in t+1; rr_ptr=2.
- All three valid continuously for 6 cycles from reset: grant order 0,1,2,0,1,2; wb_valid_o high every cycle from t+1.
- hf_busy_i high for 4 cycles with all valid: req_ready_o=0 and wb_valid_o=0 throughout. First grant occurs the cycle after hf_busy_i falls, to rr_ptr's source.
- kill_i pulsed the same cycle source 2 (PC 0x200, exc 0x2, miss 0xDEAD) is valid: no ready, wb_valid_o=0 next cycle, one FLUSH cycle, then source 2 is granted with exc 0x2 and miss 0xDEAD forwarded.
- rsn_i asserted mid-stream with wb_valid_o=1: outputs go to 0 immediately without a clock edge. After release, the first grant goes to source 0.
